pwm_ramp_ctrl: RTL and testbench

Soft-start/soft-stop duty controller for one `pwm` channel. Accepts a target compare value over a valid/ready handshake and steps the driven `cmp` toward it, one step per RAMP_DIV PWM periods. Changes `cmp` only on a period boundary, so no glitched periods are produced. Sits between the register/command layer and a `pwm` instance, and owns that instance's reset so both counters stay aligned.

---
 rtl/pwm_ramp_ctrl_pkg.sv | 39 +++
 rtl/pwm_ramp_ctrl_period_tick.sv | 56 +++++
 rtl/pwm_ramp_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_pwm_ramp_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_ramp_ctrl_pkg.sv
// pwm_pkg: shared definitions for the PWM ramp controller.
//   - pwm_state_e : controller state encoding (IDLE, RAMP, HOLD, STOP)
//   - PWM_CNT_LEN / PWM_CNT_MAX : default counter width and last count
//   - sat_step()  : one saturating step of cur toward goal, never overshooting
package pwm_pkg;

  localparam int unsigned PWM_CNT_LEN = 8;
  localparam int unsigned PWM_CNT_MAX = 255;

  // Step arithmetic runs at this fixed width plus a carry bit; callers
  // zero-extend their CNT_LEN operands, so no intermediate can wrap.
  localparam int unsigned STEP_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RAMP = 2'd1,
    ST_HOLD = 2'd2,
    ST_STOP = 2'd3
  } pwm_state_e;

  // Up: min(cur+step, goal). Down: max(cur-step, goal) without underflow.
  function automatic logic [STEP_W-1:0] sat_step(
    input logic [STEP_W-1:0] cur,
    input logic [STEP_W-1:0] goal,
    input logic [STEP_W-1:0] step
  );
    logic [STEP_W:0] w_sum;
    logic [STEP_W:0] w_gap;
    w_sum = {1'b0, cur} + {1'b0, step};
    w_gap = {1'b0, cur} - {1'b0, goal};
    if (cur < goal) begin
      return (w_sum > {1'b0, goal}) ? goal : w_sum[STEP_W-1:0];
    end else if (cur > goal) begin
      return (w_gap <= {1'b0, step}) ? goal : (cur - step);
    end
    return cur;
  endfunction

endpackage

// File: rtl/pwm_ramp_ctrl_period_tick.sv
// pwm_period_tick: period timebase mirroring the driven pwm counter.
// Ports:
//   clk, rst      : clock, asynchronous active-low reset
//   i_div_clr     : clears the ramp divider (state entry into RAMP/STOP)
//   o_pwm_rst     : registered active-high reset for the pwm instance
//   o_prd_tick    : high while the counter sits on CNT_MAX (period boundary)
//   o_ramp_tick   : boundary on which the divider completes RAMP_DIV periods
module pwm_period_tick
  import pwm_pkg::*;
#(
  parameter int unsigned CNT_LEN  = PWM_CNT_LEN,
  parameter int unsigned CNT_MAX  = PWM_CNT_MAX,
  parameter int unsigned RAMP_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_div_clr,
  output logic o_pwm_rst,
  output logic o_prd_tick,
  output logic o_ramp_tick
);

  localparam int unsigned         DIV_W       = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [CNT_LEN-1:0]  LP_CNT_MAX  = CNT_LEN'(CNT_MAX);
  localparam logic [DIV_W-1:0]    LP_DIV_LAST = DIV_W'(RAMP_DIV - 1);

  logic               r_pwm_rst;
  logic [CNT_LEN-1:0] r_cnt;
  logic [DIV_W-1:0]   r_div;
  logic               w_wrap;

  assign w_wrap      = (r_cnt == LP_CNT_MAX);
  assign o_pwm_rst   = r_pwm_rst;
  assign o_prd_tick  = w_wrap;
  assign o_ramp_tick = w_wrap && (r_div == LP_DIV_LAST);

  // Held high through reset and released one edge later so the pwm's
  // synchronous reset and this counter leave 0 on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_pwm_rst <= 1'b1;
    else      r_pwm_rst <= 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                   r_cnt <= '0;
    else if (r_pwm_rst || w_wrap) r_cnt <= '0;
    else                        r_cnt <= r_cnt + CNT_LEN'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                          r_div <= '0;
    else if (i_div_clr || o_ramp_tick) r_div <= '0;
    else if (w_wrap)                   r_div <= r_div + DIV_W'(1);
  end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl: soft-start/soft-stop duty controller for one pwm channel.
// cmp moves toward the accepted target by STEP every RAMP_DIV periods and
// only changes on the CNT_MAX->0 wrap, so every pwm period is whole.
// Ports:
//   clk, rst             : clock (shared with pwm), async active-low reset
//   en                   : 1 = run toward target, 0 = ramp down to 0
//   tgt/tgt_valid/tgt_ready : target handshake (accept on valid & ready)
//   imm                  : only with PWM_RAMP_IMMEDIATE_EN; jump at next boundary
//   cmp                  : compare value to pwm.cmp
//   pwm_rst              : active-high synchronous reset to pwm.rst
//   prd_tick             : pulse on the last count of each period
//   busy                 : in RAMP or STOP
//   done                 : pulse when cmp reaches its goal
// Build option: define PWM_RAMP_IMMEDIATE_EN to add the imm input.
module pwm_ramp_ctrl
  import pwm_pkg::*;
#(
  parameter int unsigned CNT_LEN  = PWM_CNT_LEN,
  parameter int unsigned CNT_MAX  = PWM_CNT_MAX,
  parameter int unsigned STEP     = 4,
  parameter int unsigned RAMP_DIV = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [CNT_LEN-1:0] tgt,
  input  logic               tgt_valid,
`ifdef PWM_RAMP_IMMEDIATE_EN
  input  logic               imm,
`endif
  output logic               tgt_ready,
  output logic [CNT_LEN-1:0] cmp,
  output logic               pwm_rst,
  output logic               prd_tick,
  output logic               busy,
  output logic               done
);

  localparam logic [CNT_LEN-1:0] LP_CNT_MAX = CNT_LEN'(CNT_MAX);

  pwm_state_e         r_state;
  pwm_state_e         w_state_nxt;
  logic [CNT_LEN-1:0] r_cmp;
  logic [CNT_LEN-1:0] w_cmp_nxt;
  logic [CNT_LEN-1:0] r_tgt;
  logic [CNT_LEN-1:0] w_tgt_nxt;
  logic               r_imm;
  logic               w_imm_nxt;
  logic               r_done;
  logic               w_done_nxt;
  logic               w_div_clr;
  logic               w_pwm_rst;
  logic               w_prd_tick;
  logic               w_ramp_tick;
  logic               w_accept;
  logic               w_imm_in;
  logic [CNT_LEN-1:0] w_tgt_sat;
  logic [CNT_LEN-1:0] w_goal;
  logic               w_goal_imm;
  logic [CNT_LEN-1:0] w_step;
  logic [CNT_LEN-1:0] w_step_dn;

`ifdef PWM_RAMP_IMMEDIATE_EN
  assign w_imm_in = imm;
`else
  assign w_imm_in = 1'b0;
`endif

  pwm_period_tick #(
    .CNT_LEN  (CNT_LEN),
    .CNT_MAX  (CNT_MAX),
    .RAMP_DIV (RAMP_DIV)
  ) u_period_tick (
    .clk         (clk),
    .rst         (rst),
    .i_div_clr   (w_div_clr),
    .o_pwm_rst   (w_pwm_rst),
    .o_prd_tick  (w_prd_tick),
    .o_ramp_tick (w_ramp_tick)
  );

  assign pwm_rst   = w_pwm_rst;
  assign prd_tick  = w_prd_tick;
  assign cmp       = r_cmp;
  assign done      = r_done;
  assign w_accept  = tgt_valid && tgt_ready;
  assign w_tgt_sat = (tgt > LP_CNT_MAX) ? LP_CNT_MAX : tgt;

  // A same-cycle accept already steers this cycle's step/jump.
  assign w_goal     = w_accept ? w_tgt_sat : r_tgt;
  assign w_goal_imm = w_accept ? w_imm_in  : r_imm;
  assign w_step     = CNT_LEN'(sat_step(STEP_W'(r_cmp), STEP_W'(w_goal), STEP_W'(STEP)));
  assign w_step_dn  = CNT_LEN'(sat_step(STEP_W'(r_cmp), '0, STEP_W'(STEP)));

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next state and datapath updates
  always_comb begin
    w_state_nxt = r_state;
    w_cmp_nxt   = r_cmp;
    w_tgt_nxt   = r_tgt;
    w_imm_nxt   = r_imm;
    w_done_nxt  = 1'b0;
    w_div_clr   = 1'b0;
    if (w_accept) begin
      w_tgt_nxt = w_tgt_sat;
      w_imm_nxt = w_imm_in;
    end
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_tgt_sat != '0) begin
            w_state_nxt = ST_RAMP;
            w_div_clr   = 1'b1;
          end else begin
            w_done_nxt  = 1'b1;
          end
        end
      end
      ST_RAMP: begin
        if (!en) begin
          w_state_nxt = ST_STOP;
          w_div_clr   = 1'b1;
          w_imm_nxt   = 1'b0;
        end else if (w_goal_imm) begin
          if (w_prd_tick) begin
            w_cmp_nxt   = w_goal;
            w_done_nxt  = 1'b1;
            w_state_nxt = (w_goal == '0) ? ST_IDLE : ST_HOLD;
          end
        end else if (w_ramp_tick) begin
          w_cmp_nxt = w_step;
          if (w_step == w_goal) begin
            w_state_nxt = ST_HOLD;
            w_done_nxt  = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (!en) begin
          w_state_nxt = ST_STOP;
          w_div_clr   = 1'b1;
          w_imm_nxt   = 1'b0;
        end else if (w_accept) begin
          if (w_tgt_sat != r_cmp) begin
            w_state_nxt = ST_RAMP;
            w_div_clr   = 1'b1;
          end else begin
            w_done_nxt  = 1'b1;
          end
        end
      end
      ST_STOP: begin
        if (w_ramp_tick) begin
          w_cmp_nxt = w_step_dn;
          if (w_step_dn == '0) begin
            w_state_nxt = ST_IDLE;
            w_done_nxt  = 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs; no handshake until the pwm counter has been released.
  always_comb begin
    busy      = (r_state == ST_RAMP) || (r_state == ST_STOP);
    tgt_ready = en && (r_state != ST_STOP) && !w_pwm_rst;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cmp  <= '0;
      r_tgt  <= '0;
      r_imm  <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_cmp  <= w_cmp_nxt;
      r_tgt  <= w_tgt_nxt;
      r_imm  <= w_imm_nxt;
      r_done <= w_done_nxt;
    end
  end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Bench for pwm_ramp_ctrl: table of target vectors plus hand-written
// STOP, retarget, async-reset and oversize-target sequences.
module tb_pwm_ramp_ctrl;

  localparam int CNT_MAX  = 255;
  localparam int STEP     = 4;
  localparam int RAMP_DIV = 2;
  localparam int TICK_CYC = RAMP_DIV * (CNT_MAX + 1);
  localparam int B_MAX    = 63;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [7:0] tgt = '0;
  logic       tgt_valid = 1'b0;
  logic       tgt_ready, pwm_rst, prd_tick, busy, done;
  logic [7:0] cmp;
`ifdef PWM_RAMP_IMMEDIATE_EN
  logic       imm = 1'b0;
  logic       b_imm = 1'b0;
`endif

  logic       b_en = 1'b1;
  logic [9:0] b_tgt = '0;
  logic       b_valid = 1'b0;
  logic       b_ready, b_pwm_rst, b_prd_tick, b_busy, b_done;
  logic [9:0] b_cmp;

  always #5 clk = ~clk;

  pwm_ramp_ctrl #(.CNT_LEN(8), .CNT_MAX(CNT_MAX), .STEP(STEP), .RAMP_DIV(RAMP_DIV)) dut (
    .clk(clk), .rst(rst_n), .en(en), .tgt(tgt), .tgt_valid(tgt_valid),
`ifdef PWM_RAMP_IMMEDIATE_EN
    .imm(imm),
`endif
    .tgt_ready(tgt_ready), .cmp(cmp), .pwm_rst(pwm_rst), .prd_tick(prd_tick),
    .busy(busy), .done(done)
  );

  pwm_ramp_ctrl #(.CNT_LEN(10), .CNT_MAX(B_MAX), .STEP(4), .RAMP_DIV(1)) dut_b (
    .clk(clk), .rst(rst_n), .en(b_en), .tgt(b_tgt), .tgt_valid(b_valid),
`ifdef PWM_RAMP_IMMEDIATE_EN
    .imm(b_imm),
`endif
    .tgt_ready(b_ready), .cmp(b_cmp), .pwm_rst(b_pwm_rst), .prd_tick(b_prd_tick),
    .busy(b_busy), .done(b_done)
  );

  typedef struct { logic [7:0] cmp; logic done; int gap; } sb_t;
  typedef struct { logic [7:0] tgt; logic [7:0] exp_cmp; int exp_steps; } vec_t;

  sb_t  sb_q[$];
  vec_t vecs[7];
  int   n_tests = 0, n_fail = 0;
  int   n_done = 0, n_steps = 0, n_align_err = 0;
  int   b_n_done = 0, b_n_steps = 0;
  int   cyc = 0, last_chg = 0, m_cnt = 0;
  int   steps0, done0;
  logic [7:0] model_cmp = '0;
  logic [7:0] prev_cmp = '0;
  logic [9:0] b_prev = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference pwm counter, reset synchronously by pwm_rst like a real pwm.
  always @(posedge clk) begin
    cyc++;
    if (pwm_rst)             m_cnt <= 0;
    else if (m_cnt == CNT_MAX) m_cnt <= 0;
    else                     m_cnt <= m_cnt + 1;
  end

  // Scoreboard monitor: every cmp change must match the queue head and land on count 0.
  always @(negedge clk) begin
    if (rst_n) begin
      if (prd_tick !== (m_cnt == CNT_MAX)) n_align_err++;
      if (done === 1'b1) n_done++;
      if (cmp !== prev_cmp) begin
        n_steps++;
        if (sb_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_unexpected: cmp changed to 0x%0h with nothing expected", cmp);
        end else begin
          sb_t e;
          e = sb_q.pop_front();
          check("sb_cmp", 32'(cmp), 32'(e.cmp));
          check("sb_done", 32'(done), 32'(e.done));
          check("sb_at_cnt0", m_cnt, 0);
          if (e.gap != 0) check("sb_gap", cyc - last_chg, e.gap);
        end
        last_chg = cyc;
      end
      if (b_done === 1'b1) b_n_done++;
      if (b_cmp !== b_prev) b_n_steps++;
    end
    prev_cmp = cmp;
    b_prev   = b_cmp;
  end

  task automatic push_ramp(input logic [7:0] src, input logic [7:0] dst,
                           input logic last_done, input int first_gap);
    int cur, g;
    bit first;
    sb_t e;
    cur = int'(src);
    g = int'(dst);
    first = 1'b1;
    while (cur != g) begin
      if (cur < g) cur = (cur + STEP >= g) ? g : cur + STEP;
      else         cur = (cur - STEP <= g) ? g : cur - STEP;
      e.cmp  = 8'(cur);
      e.done = (cur == g) ? last_done : 1'b0;
      e.gap  = first ? first_gap : TICK_CYC;
      first  = 1'b0;
      sb_q.push_back(e);
    end
  endtask

  task automatic send(input logic [7:0] v);
    int k;
    k = 0;
    @(negedge clk);
    tgt = v;
    tgt_valid = 1'b1;
    while (!tgt_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("hs_ready", 32'(tgt_ready), 1);
    if (tgt_ready) begin
      @(posedge clk);
      #1;
    end
    tgt_valid = 1'b0;
  endtask

  task automatic wait_done(input int target, input int max_cyc, input string name);
    int k;
    k = 0;
    while (n_done < target && k < max_cyc) begin
      @(negedge clk);
      k++;
    end
    check(name, 32'(n_done >= target), 1);
  endtask

  task automatic wait_sb(input int max_left, input int max_cyc, input string name);
    int k;
    k = 0;
    while (sb_q.size() > max_left && k < max_cyc) begin
      @(negedge clk);
      k++;
    end
    check(name, 32'(sb_q.size() <= max_left), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  initial begin
    vecs[0] = '{8'h00, 8'h00, 0};
    vecs[1] = '{8'h10, 8'h10, 4};
    vecs[2] = '{8'h12, 8'h12, 1};
    vecs[3] = '{8'h08, 8'h08, 3};
    vecs[4] = '{8'h08, 8'h08, 0};
    vecs[5] = '{8'h20, 8'h20, 6};
    vecs[6] = '{8'h40, 8'h40, 8};

    // Reset state, with en already high
    en = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_cmp", 32'(cmp), 0);
    check("rst_pwm_rst", 32'(pwm_rst), 1);
    check("rst_prd_tick", 32'(prd_tick), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_ready", 32'(tgt_ready), 0);
    rst_n = 1'b1;
    #1;
    check("rel_pwm_rst_held", 32'(pwm_rst), 1);
    @(negedge clk);
    check("rel_pwm_rst_clear", 32'(pwm_rst), 0);
    check("rel_ready", 32'(tgt_ready), 1);

    // Table of targets, each waited to completion
    foreach (vecs[i]) begin
      steps0 = n_steps;
      done0  = n_done;
      push_ramp(model_cmp, vecs[i].tgt, 1'b1, 0);
      send(vecs[i].tgt);
      wait_done(done0 + 1, (vecs[i].exp_steps + 2) * TICK_CYC + 20, "vec_done_seen");
      repeat (2) @(negedge clk);
      check("vec_cmp", 32'(cmp), 32'(vecs[i].exp_cmp));
      check("vec_steps", n_steps - steps0, vecs[i].exp_steps);
      check("vec_ndone", n_done - done0, 1);
      check("vec_busy", 32'(busy), 0);
      check("vec_sb_empty", sb_q.size(), 0);
      model_cmp = vecs[i].exp_cmp;
    end

    // HOLD at 0x40, drop en: ramp down to 0, target offered during STOP is ignored
    steps0 = n_steps;
    done0  = n_done;
    push_ramp(8'h40, 8'h00, 1'b1, 0);
    @(negedge clk);
    en = 1'b0;
    #1;
    check("stop_ready_low", 32'(tgt_ready), 0);
    @(negedge clk);
    check("stop_busy", 32'(busy), 1);
    en = 1'b1;
    tgt = 8'h30;
    tgt_valid = 1'b1;
    @(negedge clk);
    check("stop_ready_en1", 32'(tgt_ready), 0);
    repeat (3) @(negedge clk);
    tgt_valid = 1'b0;
    wait_done(done0 + 1, 18 * TICK_CYC, "stop_done_seen");
    repeat (2) @(negedge clk);
    check("stop_cmp", 32'(cmp), 0);
    check("stop_steps", n_steps - steps0, 16);
    check("stop_busy_end", 32'(busy), 0);
    check("stop_idle_ready", 32'(tgt_ready), 1);
    check("stop_sb_empty", sb_q.size(), 0);

    // Rising to 0x80, retarget to 0x10 at 0x20; divider keeps its phase
    steps0 = n_steps;
    done0  = n_done;
    push_ramp(8'h00, 8'h20, 1'b0, 0);
    send(8'h80);
    wait_sb(0, 10 * TICK_CYC, "rt_reach_20");
    check("rt_at_20", 32'(cmp), 32'h20);
    push_ramp(8'h20, 8'h10, 1'b1, TICK_CYC);
    send(8'h10);
    wait_done(done0 + 1, 6 * TICK_CYC, "rt_done_seen");
    repeat (2) @(negedge clk);
    check("rt_cmp", 32'(cmp), 32'h10);
    check("rt_steps", n_steps - steps0, 12);
    check("rt_busy", 32'(busy), 0);

    // Async reset mid-RAMP, between clock edges
    push_ramp(8'h10, 8'h40, 1'b1, 0);
    send(8'h40);
    wait_sb(10, 5 * TICK_CYC, "mr_two_steps");
    check("mr_busy_before", 32'(busy), 1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mr_cmp", 32'(cmp), 0);
    check("mr_pwm_rst", 32'(pwm_rst), 1);
    check("mr_busy", 32'(busy), 0);
    check("mr_ready", 32'(tgt_ready), 0);
    sb_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_cmp = '0;
    @(negedge clk);
    check("mr_rel_pwm_rst", 32'(pwm_rst), 0);
    check("mr_rel_cmp", 32'(cmp), 0);

    // Wider counter: oversize target clipped to CNT_MAX
    @(negedge clk);
    check("b_ready", 32'(b_ready), 1);
    b_tgt = 10'h300;
    b_valid = 1'b1;
    @(posedge clk);
    #1;
    b_valid = 1'b0;
    for (int k = 0; k < 20 * (B_MAX + 1) && b_n_done == 0; k++) @(negedge clk);
    repeat (2) @(negedge clk);
    check("b_done_seen", b_n_done, 1);
    check("b_cmp_clip", 32'(b_cmp), B_MAX);
    check("b_steps", b_n_steps, 16);
    check("b_busy", 32'(b_busy), 0);

`ifdef PWM_RAMP_IMMEDIATE_EN
    begin
      sb_t e;
      steps0 = n_steps;
      done0  = n_done;
      e.cmp = 8'h55; e.done = 1'b1; e.gap = 0;
      sb_q.push_back(e);
      imm = 1'b1;
      send(8'h55);
      imm = 1'b0;
      wait_done(done0 + 1, 2 * (CNT_MAX + 1) + 10, "imm_done_seen");
      repeat (2) @(negedge clk);
      check("imm_cmp", 32'(cmp), 32'h55);
      check("imm_steps", n_steps - steps0, 1);
      check("imm_busy", 32'(busy), 0);
    end
`endif

    check("prd_tick_align", n_align_err, 0);
    check("final_sb_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
